lcd_cmd_sequencer: RTL and testbench

//   Host-side driver placed directly upstream of lcd_ctrl. Queues host commands in a small FIFO and

---
 rtl/lcd_pkg.sv | 29 ++
 rtl/lcd_cmd_fifo.sv | 71 +++++++
 rtl/lcd_cmd_sequencer.sv | 140 ++++++++++++++
 tb/tb_lcd_cmd_sequencer.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the lcd_ctrl host-side command path: command codes,
// image geometry and the sequencer state encoding.
package lcd_pkg;

    localparam int IMG_W     = 12;
    localparam int IMG_H     = 9;
    localparam int IMG_BYTES = IMG_W * IMG_H;

    typedef enum logic [2:0] {
        CMD_LOAD     = 3'd0,
        CMD_ZOOM_IN  = 3'd1,
        CMD_ZOOM_FIT = 3'd2,
        CMD_SHIFT_R  = 3'd3,
        CMD_SHIFT_L  = 3'd4,
        CMD_SHIFT_U  = 3'd5,
        CMD_SHIFT_D  = 3'd6
    } lcd_cmd_e;

    // Code 7 is reserved; it is rejected at the push port and never queued.
    localparam logic [2:0] CMD_ILLEGAL = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_LOAD,
        S_GUARD_W
    } seq_state_e;

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Small synchronous command FIFO with registered count and full/empty flags.
// The head entry is visible on dout so it can be captured at the pop edge.
module lcd_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty
);

    localparam int PW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [PW:0]   count_reg;
    logic [PW:0]   count_next;
    logic          full_reg;
    logic          empty_reg;
    logic          do_push;
    logic          do_pop;

    // Push is gated by the registered full flag, so a same-cycle pop never frees a slot.
    assign do_push = push && !full_reg;
    assign do_pop  = pop && !empty_reg;

    always_comb begin
        count_next = count_reg;
        case ({do_push, do_pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            full_reg   <= 1'b0;
            empty_reg  <= 1'b1;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_next;
            full_reg  <= (count_next == (PW+1)'(DEPTH));
            empty_reg <= (count_next == '0);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (do_push && (wr_ptr_reg == PW'(gi))) mem[gi] <= din;
            end
        end
    endgenerate

    assign dout  = mem[rd_ptr_reg];
    assign full  = full_reg;
    assign empty = empty_reg;

endmodule

// File: rtl/lcd_cmd_sequencer.sv
// Queues host commands and dispatches them to lcd_ctrl while it is not busy;
// a LOAD additionally streams the whole image from the synchronous ROM onto datain.
module lcd_cmd_sequencer
    import lcd_pkg::*;
#(
    parameter int ADDR_W     = 7,
    parameter int FIFO_DEPTH = 4,
    parameter int GUARD      = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        cmd_in,
    input  logic              cmd_in_valid,
    output logic              cmd_in_ready,
    output logic              cmd_err,
    output logic              img_rd,
    output logic [ADDR_W-1:0] img_addr,
    input  logic [7:0]        img_data,
    input  logic              busy,
    output logic [2:0]        cmd,
    output logic              cmd_valid,
    output logic [7:0]        datain,
    output logic              seq_idle,
    output logic [7:0]        issue_cnt
);

    localparam int         GW         = (GUARD > 1) ? $clog2(GUARD) : 1;
    localparam logic [6:0] BYTE_LAST  = 7'(IMG_BYTES - 1);
    localparam logic [6:0] BYTE_PEN   = 7'(IMG_BYTES - 2);
    localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD - 1);

    seq_state_e        state_reg;
    logic              cmd_valid_reg;
    logic [2:0]        cmd_reg;
    logic              img_rd_reg;
    logic [ADDR_W-1:0] img_addr_reg;
    logic              cmd_err_reg;
    logic [7:0]        issue_cnt_reg;
    logic [6:0]        byte_cnt_reg;
    logic [GW-1:0]     guard_cnt_reg;

    logic [2:0] fifo_dout;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_push;
    logic       fifo_pop;

    assign fifo_push = cmd_in_valid && (cmd_in != CMD_ILLEGAL);
    assign fifo_pop  = (state_reg == S_IDLE) && !fifo_empty && !busy;

    lcd_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .DW    (3)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (cmd_in),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            cmd_valid_reg <= 1'b0;
            cmd_reg       <= '0;
            img_rd_reg    <= 1'b0;
            img_addr_reg  <= '0;
            cmd_err_reg   <= 1'b0;
            issue_cnt_reg <= '0;
            byte_cnt_reg  <= '0;
            guard_cnt_reg <= '0;
        end else begin
            cmd_err_reg <= cmd_in_valid && !fifo_full && (cmd_in == CMD_ILLEGAL);
            case (state_reg)
                S_IDLE: begin
                    if (fifo_pop) begin
                        state_reg     <= S_ISSUE;
                        cmd_valid_reg <= 1'b1;
                        cmd_reg       <= fifo_dout;
                        issue_cnt_reg <= issue_cnt_reg + 1'b1;
                        // The first ROM read is launched alongside cmd_valid so byte 0 lands next cycle.
                        if (fifo_dout == CMD_LOAD) begin
                            img_rd_reg   <= 1'b1;
                            img_addr_reg <= '0;
                        end
                    end
                end
                S_ISSUE: begin
                    cmd_valid_reg <= 1'b0;
                    cmd_reg       <= '0;
                    byte_cnt_reg  <= '0;
                    guard_cnt_reg <= '0;
                    if (cmd_reg == CMD_LOAD) begin
                        state_reg    <= S_LOAD;
                        img_addr_reg <= ADDR_W'(1);
                    end else begin
                        state_reg <= S_GUARD_W;
                    end
                end
                S_LOAD: begin
                    if (byte_cnt_reg == BYTE_LAST) begin
                        state_reg    <= S_GUARD_W;
                        byte_cnt_reg <= '0;
                    end else begin
                        byte_cnt_reg <= byte_cnt_reg + 1'b1;
                        if (byte_cnt_reg == BYTE_PEN) begin
                            img_rd_reg   <= 1'b0;
                            img_addr_reg <= '0;
                        end else begin
                            img_addr_reg <= img_addr_reg + ADDR_W'(1);
                        end
                    end
                end
                S_GUARD_W: begin
                    if (guard_cnt_reg == GUARD_LAST) begin
                        state_reg <= S_IDLE;
                    end else begin
                        guard_cnt_reg <= guard_cnt_reg + 1'b1;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign datain       = (state_reg == S_LOAD) ? img_data : 8'h00;
    assign seq_idle     = (state_reg == S_IDLE) && fifo_empty;
    assign cmd_in_ready = !fifo_full;
    assign cmd_valid    = cmd_valid_reg;
    assign cmd          = cmd_reg;
    assign img_rd       = img_rd_reg;
    assign img_addr     = img_addr_reg;
    assign cmd_err      = cmd_err_reg;
    assign issue_cnt    = issue_cnt_reg;

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// Bench for lcd_cmd_sequencer: directed scenarios followed by random traffic, every
// cycle checked against a transaction-level model of queueing, dispatch spacing and streaming.
module tb_lcd_cmd_sequencer;
    import lcd_pkg::*;

    localparam int ADDR_W = 7;
    localparam int DEPTH  = 4;
    localparam int GUARD  = 1;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [2:0]        cmd_in = '0;
    logic              cmd_in_valid = 1'b0;
    logic              busy = 1'b0;
    logic              cmd_in_ready;
    logic              cmd_err;
    logic              img_rd;
    logic [ADDR_W-1:0] img_addr;
    logic [7:0]        img_data = 8'h00;
    logic [2:0]        cmd;
    logic              cmd_valid;
    logic [7:0]        datain;
    logic              seq_idle;
    logic [7:0]        issue_cnt;

    logic [7:0] rom [128];

    always #5 clk = ~clk;

    // Synchronous image ROM: data valid the cycle after the read.
    always @(posedge clk) if (img_rd) img_data <= rom[img_addr];

    lcd_cmd_sequencer #(.ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH), .GUARD(GUARD)) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_in       (cmd_in),
        .cmd_in_valid (cmd_in_valid),
        .cmd_in_ready (cmd_in_ready),
        .cmd_err      (cmd_err),
        .img_rd       (img_rd),
        .img_addr     (img_addr),
        .img_data     (img_data),
        .busy         (busy),
        .cmd          (cmd),
        .cmd_valid    (cmd_valid),
        .datain       (datain),
        .seq_idle     (seq_idle),
        .issue_cnt    (issue_cnt)
    );

    int compared   = 0;
    int mismatched = 0;

    // Reference model state
    int         q[$];
    int         cyc     = 0;
    int         free_at = 0;
    int         load_t  = -1;
    logic [7:0] m_cnt   = 8'h00;
    logic       m_valid = 1'b0;
    logic [2:0] m_cmd   = 3'd0;
    logic       m_err   = 1'b0;
    logic       m_rst   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance model over the edge, then compare every output.
    task automatic step(input logic v, input logic [2:0] c, input logic b, input logic r);
        int         sz;
        int         k;
        logic       e_rd;
        logic [7:0] e_d;
        cmd_in_valid = v;
        cmd_in       = c;
        busy         = b;
        reset        = r;
        @(posedge clk);
        cyc++;
        m_rst = r;
        if (r) begin
            q.delete();
            m_cnt   = 8'h00;
            load_t  = -1;
            free_at = cyc + 1;
            m_valid = 1'b0;
            m_cmd   = 3'd0;
            m_err   = 1'b0;
        end else begin
            sz      = q.size();
            m_valid = 1'b0;
            m_cmd   = 3'd0;
            if (sz > 0 && !b && cyc >= free_at) begin
                m_cmd   = 3'(q.pop_front());
                m_valid = 1'b1;
                m_cnt   = m_cnt + 8'd1;
                free_at = cyc + 2 + GUARD + ((m_cmd == 3'd0) ? IMG_BYTES : 0);
                if (m_cmd == 3'd0) load_t = cyc;
            end
            m_err = v && (sz < DEPTH) && (c == 3'd7);
            if (v && (sz < DEPTH) && (c != 3'd7)) q.push_back(int'(c));
        end
        k    = cyc - load_t;
        e_rd = (load_t >= 0) && (k >= 0) && (k <= IMG_BYTES - 1);
        e_d  = ((load_t >= 0) && (k >= 1) && (k <= IMG_BYTES)) ? rom[k-1] : 8'h00;
        #1;
        chk("cmd_valid", 32'(cmd_valid), 32'(m_valid));
        chk("cmd", 32'(cmd), 32'(m_cmd));
        chk("datain", 32'(datain), 32'(e_d));
        chk("img_rd", 32'(img_rd), 32'(e_rd));
        if (e_rd) chk("img_addr", 32'(img_addr), 32'(k));
        if (m_rst) chk("img_addr_rst", 32'(img_addr), 32'd0);
        chk("cmd_err", 32'(cmd_err), 32'(m_err));
        chk("issue_cnt", 32'(issue_cnt), 32'(m_cnt));
        chk("seq_idle", 32'(seq_idle), 32'((q.size() == 0) && (cyc >= free_at - 1)));
        chk("cmd_in_ready", 32'(cmd_in_ready), 32'(q.size() < DEPTH));
    endtask

    task automatic idle(input int n, input logic b);
        for (int i = 0; i < n; i++) step(1'b0, 3'd0, b, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) rom[i] = 8'(i + 16);

        // Reset state
        step(1'b0, 3'd0, 1'b0, 1'b1);
        step(1'b0, 3'd0, 1'b0, 1'b1);

        // Full image load
        step(1'b1, 3'd0, 1'b0, 1'b0);
        idle(115, 1'b0);

        // Commands held off by busy, then issued in order
        step(1'b1, 3'd3, 1'b1, 1'b0);
        step(1'b1, 3'd6, 1'b1, 1'b0);
        step(1'b1, 3'd1, 1'b1, 1'b0);
        idle(6, 1'b1);
        idle(15, 1'b0);

        // Overfill: fifth push dropped
        step(1'b1, 3'd2, 1'b1, 1'b0);
        step(1'b1, 3'd4, 1'b1, 1'b0);
        step(1'b1, 3'd5, 1'b1, 1'b0);
        step(1'b1, 3'd3, 1'b1, 1'b0);
        step(1'b1, 3'd6, 1'b1, 1'b0);
        idle(3, 1'b1);
        idle(20, 1'b0);

        // Illegal command
        step(1'b1, 3'd7, 1'b0, 1'b0);
        idle(5, 1'b0);

        // Reset in the middle of a load, then a clean reload
        step(1'b1, 3'd0, 1'b0, 1'b0);
        idle(52, 1'b0);
        step(1'b0, 3'd0, 1'b0, 1'b1);
        idle(2, 1'b0);
        step(1'b1, 3'd0, 1'b0, 1'b0);
        idle(115, 1'b0);

        // Random traffic with a fresh image
        for (int i = 0; i < 128; i++) rom[i] = 8'($urandom);
        for (int i = 0; i < 1800; i++) begin
            logic       v;
            logic [2:0] c;
            logic       b;
            logic       r;
            v = ($urandom_range(0, 9) < 3);
            c = ($urandom_range(0, 19) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
            b = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 599) == 0);
            step(v, c, b, r);
        end
        idle(120, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
